// File: rtl/pipeline_rr_stage.sv
// Read-register stage between decode and execute; holds decoded fields, valid bit, load-use bubble FSM.
// Latency: 1 cycle from *_in to *_out on an update edge; loads/imm_out/stall_req are combinational.
// Backpressure: stall_req asks upstream to hold while a load-use hazard is pending or bubbles remain.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   update, flush             stage advance enable, synchronous kill (flush wins over everything but rst)
//   valid_in, *_in            incoming instruction valid and decoded fields
//   valid_out, *_out          registered copies of the decoded fields
//   loads                     stage holds a valid load instruction
//   stall_req                 upstream must hold this cycle
module pipeline_rr_stage #(
    parameter int CTRL_W        = 22,
    parameter int RNUM_W        = 3,
    parameter int IMM_W         = 16,
    parameter int TYPE_W        = 6,
    parameter int DLYB_W        = 16,
    parameter int COND_W        = 3,
    parameter int LOAD_BIT      = 8,
    parameter int BL_TYPE_BIT   = 2,
    parameter int BL_IMM_W      = 8,
    parameter int LOADUSE_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] control_in,
    input  logic [RNUM_W-1:0] num_Rm_in,
    input  logic [RNUM_W-1:0] num_Rn_in,
    input  logic [RNUM_W-1:0] num_Rd_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [2:0]        used_RmRnRd_in,
    input  logic [TYPE_W-1:0] inst_type_in,
    input  logic [DLYB_W-1:0] delayed_B_in,
    input  logic [COND_W-1:0] delayed_cond_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] control_out,
    output logic [RNUM_W-1:0] num_Rm_out,
    output logic [RNUM_W-1:0] num_Rn_out,
    output logic [RNUM_W-1:0] num_Rd_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [2:0]        used_RmRnRd_out,
    output logic [TYPE_W-1:0] inst_type_out,
    output logic [DLYB_W-1:0] delayed_B_out,
    output logic [COND_W-1:0] delayed_cond_out,
    output logic              loads,
    output logic              stall_req
);

    // One extra bit so LOADUSE_STALL itself never overflows the counter.
    localparam int CNT_W = $clog2(LOADUSE_STALL) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IMM_W-1:0] imm_q;

    logic             hazard;
    logic             rm_hit;
    logic             rn_hit;
    logic             rd_hit;
    logic             bubble;
    logic             advance;

    // ------------------------------------------------------------------
    // Hazard detection against the load currently held in this stage
    // ------------------------------------------------------------------
    always_comb begin
        loads  = valid_out & control_out[LOAD_BIT];
        rm_hit = used_RmRnRd_in[2] & (num_Rm_in == num_Rd_out);
        rn_hit = used_RmRnRd_in[1] & (num_Rn_in == num_Rd_out);
        rd_hit = used_RmRnRd_in[0] & (num_Rd_in == num_Rd_out);
        hazard = valid_in & loads & (rm_hit | rn_hit | rd_hit);
    end

    // A bubble is written on a fresh hazard, and on every STALL cycle regardless
    // of the inputs (the hazard has already been charged its full bubble count).
    always_comb begin
        bubble    = (state == STALL) ? 1'b1 : hazard;
        stall_req = hazard | (state == STALL);
        advance   = update & ~flush & ~bubble;
    end

    // ------------------------------------------------------------------
    // Reset-class fields and bubble FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out        <= 1'b0;
            control_out      <= '0;
            used_RmRnRd_out  <= '0;
            inst_type_out    <= '0;
            delayed_cond_out <= '0;
            state            <= IDLE;
            cnt              <= '0;
        end else if (flush) begin
            // Flush also abandons any bubbles still owed.
            valid_out        <= 1'b0;
            control_out      <= '0;
            used_RmRnRd_out  <= '0;
            inst_type_out    <= '0;
            delayed_cond_out <= '0;
            state            <= IDLE;
            cnt              <= '0;
        end else if (update) begin
            if (bubble) begin
                valid_out        <= 1'b0;
                control_out      <= '0;
                used_RmRnRd_out  <= '0;
                inst_type_out    <= '0;
                delayed_cond_out <= '0;
                case (state)
                    IDLE: begin
                        // This edge is the first bubble; the rest are counted in STALL.
                        if (LOADUSE_STALL > 1) begin
                            state <= STALL;
                            cnt   <= CNT_W'(LOADUSE_STALL - 1);
                        end
                    end
                    STALL: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end else begin
                valid_out        <= valid_in;
                control_out      <= control_in;
                used_RmRnRd_out  <= used_RmRnRd_in;
                inst_type_out    <= inst_type_in;
                delayed_cond_out <= delayed_cond_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath-class fields: no reset, only written on a real advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (advance) begin
            num_Rm_out    <= num_Rm_in;
            num_Rn_out    <= num_Rn_in;
            num_Rd_out    <= num_Rd_in;
            imm_q         <= imm_in;
            delayed_B_out <= delayed_B_in;
        end
    end

    // BL/BLX take their immediate from the low bits of the delayed-branch word.
    always_comb begin
        imm_out = imm_q;
        if (inst_type_out[BL_TYPE_BIT]) begin
            imm_out                 = '0;
            imm_out[BL_IMM_W-1:0]   = delayed_B_out[BL_IMM_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipeline_rr_stage.sv
// Bench for pipeline_rr_stage: two instances (1 and 3 load-use bubbles) share one stimulus stream.
// Expected stage contents are pushed per instance when inputs are driven and popped after the edge.
module tb_pipeline_rr_stage;

    localparam int ACC  = 0;   // stage loads the inputs
    localparam int BUB  = 1;   // bubble or flush: reset class cleared, datapath held
    localparam int HOLD = 2;   // update low: everything held

    typedef struct packed {
        logic        valid;
        logic        loads;
        logic [21:0] ctrl;
        logic [2:0]  used;
        logic [5:0]  typ;
        logic [2:0]  cond;
        logic [2:0]  rm;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic [15:0] dlyb;
    } obs_t;

    typedef struct {
        logic        valid;
        logic [21:0] ctrl;
        logic [2:0]  used;
        logic [5:0]  typ;
        logic [2:0]  cond;
        logic [2:0]  rm;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic [15:0] dlyb;
        bit          dp_known;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, update, flush, valid_in;
    logic [21:0] control_in;
    logic [2:0]  num_Rm_in, num_Rn_in, num_Rd_in, used_in, cond_in;
    logic [15:0] imm_in, dlyb_in;
    logic [5:0]  type_in;

    logic        valid_1, loads_1, stall_1, valid_3, loads_3, stall_3;
    logic [21:0] ctrl_1, ctrl_3;
    logic [2:0]  rm_1, rn_1, rd_1, used_1, cond_1, rm_3, rn_3, rd_3, used_3, cond_3;
    logic [15:0] imm_1, dlyb_1, imm_3, dlyb_3;
    logic [5:0]  type_1, type_3;

    obs_t o1, o3;
    exp_t m1, m3;
    exp_t q1[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_rr_stage #(.LOADUSE_STALL(1)) u1 (
        .clk(clk), .rst(rst), .update(update), .flush(flush), .valid_in(valid_in),
        .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
        .num_Rd_in(num_Rd_in), .imm_in(imm_in), .used_RmRnRd_in(used_in),
        .inst_type_in(type_in), .delayed_B_in(dlyb_in), .delayed_cond_in(cond_in),
        .valid_out(valid_1), .control_out(ctrl_1), .num_Rm_out(rm_1), .num_Rn_out(rn_1),
        .num_Rd_out(rd_1), .imm_out(imm_1), .used_RmRnRd_out(used_1), .inst_type_out(type_1),
        .delayed_B_out(dlyb_1), .delayed_cond_out(cond_1), .loads(loads_1), .stall_req(stall_1)
    );

    pipeline_rr_stage #(.LOADUSE_STALL(3)) u3 (
        .clk(clk), .rst(rst), .update(update), .flush(flush), .valid_in(valid_in),
        .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
        .num_Rd_in(num_Rd_in), .imm_in(imm_in), .used_RmRnRd_in(used_in),
        .inst_type_in(type_in), .delayed_B_in(dlyb_in), .delayed_cond_in(cond_in),
        .valid_out(valid_3), .control_out(ctrl_3), .num_Rm_out(rm_3), .num_Rn_out(rn_3),
        .num_Rd_out(rd_3), .imm_out(imm_3), .used_RmRnRd_out(used_3), .inst_type_out(type_3),
        .delayed_B_out(dlyb_3), .delayed_cond_out(cond_3), .loads(loads_3), .stall_req(stall_3)
    );

    assign o1 = {valid_1, loads_1, ctrl_1, used_1, type_1, cond_1, rm_1, rn_1, rd_1, imm_1, dlyb_1};
    assign o3 = {valid_3, loads_3, ctrl_3, used_3, type_3, cond_3, rm_3, rn_3, rd_3, imm_3, dlyb_3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_obs(input string who, input obs_t o, input exp_t e);
        logic [15:0] ex_imm;
        ex_imm = e.typ[2] ? {8'h00, e.dlyb[7:0]} : e.imm;
        chk({who, ".valid"}, 32'(o.valid), 32'(e.valid));
        chk({who, ".loads"}, 32'(o.loads), 32'(e.valid & e.ctrl[8]));
        chk({who, ".ctrl"},  32'(o.ctrl),  32'(e.ctrl));
        chk({who, ".used"},  32'(o.used),  32'(e.used));
        chk({who, ".type"},  32'(o.typ),   32'(e.typ));
        chk({who, ".cond"},  32'(o.cond),  32'(e.cond));
        if (e.dp_known) begin
            chk({who, ".imm"},  32'(o.imm),  32'(ex_imm));
            chk({who, ".rm"},   32'(o.rm),   32'(e.rm));
            chk({who, ".rn"},   32'(o.rn),   32'(e.rn));
            chk({who, ".rd"},   32'(o.rd),   32'(e.rd));
            chk({who, ".dlyb"}, 32'(o.dlyb), 32'(e.dlyb));
        end
    endtask

    function automatic exp_t next_m(input int md, input exp_t m);
        exp_t n;
        n = m;
        if (md == ACC) begin
            n.valid = valid_in;   n.ctrl = control_in; n.used = used_in;
            n.typ   = type_in;    n.cond = cond_in;    n.rm   = num_Rm_in;
            n.rn    = num_Rn_in;  n.rd   = num_Rd_in;  n.imm  = imm_in;
            n.dlyb  = dlyb_in;    n.dp_known = 1'b1;
        end else if (md == BUB) begin
            n.valid = 1'b0; n.ctrl = '0; n.used = '0; n.typ = '0; n.cond = '0;
        end
        return n;
    endfunction

    task automatic drv(input logic v, input logic [21:0] c, input logic [2:0] rm, rn, rd,
                       input logic [15:0] imm, input logic [2:0] used, input logic [5:0] typ,
                       input logic [15:0] dlyb, input logic [2:0] cond);
        valid_in = v; control_in = c; num_Rm_in = rm; num_Rn_in = rn; num_Rd_in = rd;
        imm_in = imm; used_in = used; type_in = typ; dlyb_in = dlyb; cond_in = cond;
    endtask

    // Check stall_req for the driven inputs, predict both stages, clock, compare.
    task automatic cyc(input int md1, input int md3, input logic s1, input logic s3);
        exp_t e;
        #1;
        chk("u1.stall_req", 32'(stall_1), 32'(s1));
        chk("u3.stall_req", 32'(stall_3), 32'(s3));
        q1.push_back(next_m(md1, m1)); m1 = q1[$];
        q3.push_back(next_m(md3, m3)); m3 = q3[$];
        @(posedge clk); #1;
        e = q1.pop_front(); check_obs("u1", o1, e);
        e = q3.pop_front(); check_obs("u3", o3, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state (valid_in high to show stall_req stays low while loads = 0)
        rst = 1'b1; update = 1'b1; flush = 1'b0;
        drv(1'b1, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0, 3'b111, 6'd0, 16'h0, 3'd0);
        m1 = '{default: '0}; m3 = '{default: '0};
        repeat (2) @(posedge clk);
        #1;
        check_obs("rst.u1", o1, m1);
        check_obs("rst.u3", o3, m3);
        chk("rst.u1.stall_req", 32'(stall_1), 32'd0);
        chk("rst.u3.stall_req", 32'(stall_3), 32'd0);
        rst = 1'b0;

        // Full control word, then asynchronous reset mid-cycle
        drv(1'b1, 22'h3FFFFF, 3'd1, 3'd2, 3'd3, 16'h1111, 3'b000, 6'd0, 16'h2222, 3'd5);
        cyc(ACC, ACC, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst.u1.ctrl",  32'(ctrl_1),  32'd0);
        chk("arst.u1.valid", 32'(valid_1), 32'd0);
        chk("arst.u1.loads", 32'(loads_1), 32'd0);
        chk("arst.u3.ctrl",  32'(ctrl_3),  32'd0);
        rst = 1'b0;
        m1 = next_m(BUB, m1); m1.dp_known = 1'b0;
        m3 = next_m(BUB, m3); m3.dp_known = 1'b0;

        // BL immediate selection
        drv(1'b1, 22'h0, 3'd1, 3'd2, 3'd3, 16'h1234, 3'b000, 6'b000100, 16'hABCD, 3'd2);
        cyc(ACC, ACC, 1'b0, 1'b0);
        chk("bl.imm_out", 32'(imm_1), 32'h00CD);
        type_in = 6'd0;
        cyc(ACC, ACC, 1'b0, 1'b0);
        chk("nonbl.imm_out", 32'(imm_1), 32'h1234);

        // Load-use on Rm: 1 bubble vs 3 bubbles, with 2 cycles of update low mid-stall
        drv(1'b1, 22'h000100, 3'd1, 3'd2, 3'd5, 16'h0AAA, 3'b001, 6'd0, 16'h0001, 3'd1);
        cyc(ACC, ACC, 1'b0, 1'b0);
        drv(1'b1, 22'h000001, 3'd5, 3'd0, 3'd6, 16'h0055, 3'b100, 6'd0, 16'h0002, 3'd0);
        cyc(BUB, BUB, 1'b1, 1'b1);
        update = 1'b0;
        cyc(HOLD, HOLD, 1'b0, 1'b1);
        cyc(HOLD, HOLD, 1'b0, 1'b1);
        update = 1'b1;
        cyc(ACC, BUB, 1'b0, 1'b1);
        cyc(ACC, BUB, 1'b0, 1'b1);
        cyc(ACC, ACC, 1'b0, 1'b0);

        // Matching Rn but Rn not read: no hazard
        drv(1'b1, 22'h000100, 3'd1, 3'd2, 3'd5, 16'h0AAA, 3'b001, 6'd0, 16'h0001, 3'd1);
        cyc(ACC, ACC, 1'b0, 1'b0);
        drv(1'b1, 22'h000002, 3'd7, 3'd5, 3'd6, 16'h0077, 3'b100, 6'd0, 16'h0003, 3'd3);
        cyc(ACC, ACC, 1'b0, 1'b0);

        // Matching registers but valid_in low: no hazard
        drv(1'b1, 22'h000100, 3'd1, 3'd2, 3'd5, 16'h0BBB, 3'b001, 6'd0, 16'h0004, 3'd1);
        cyc(ACC, ACC, 1'b0, 1'b0);
        drv(1'b0, 22'h000004, 3'd5, 3'd5, 3'd5, 16'h0066, 3'b111, 6'd0, 16'h0005, 3'd4);
        cyc(ACC, ACC, 1'b0, 1'b0);

        // Load-use on Rn, then flush with update while u3 is in STALL with cnt = 2
        drv(1'b1, 22'h000100, 3'd1, 3'd2, 3'd5, 16'h0CCC, 3'b001, 6'd0, 16'h0006, 3'd1);
        cyc(ACC, ACC, 1'b0, 1'b0);
        drv(1'b1, 22'h000008, 3'd0, 3'd5, 3'd6, 16'h0088, 3'b010, 6'd0, 16'h0007, 3'd6);
        cyc(BUB, BUB, 1'b1, 1'b1);
        flush = 1'b1;
        cyc(BUB, BUB, 1'b0, 1'b1);
        flush = 1'b0;
        cyc(ACC, ACC, 1'b0, 1'b0);

        // Load-use on Rd, then flush with update low: flush still wins
        drv(1'b1, 22'h000100, 3'd1, 3'd2, 3'd5, 16'h0DDD, 3'b001, 6'd0, 16'h0008, 3'd1);
        cyc(ACC, ACC, 1'b0, 1'b0);
        drv(1'b1, 22'h000010, 3'd0, 3'd0, 3'd5, 16'h0099, 3'b001, 6'd0, 16'h0009, 3'd7);
        cyc(BUB, BUB, 1'b1, 1'b1);
        flush = 1'b1; update = 1'b0;
        cyc(BUB, BUB, 1'b0, 1'b1);
        flush = 1'b0; update = 1'b1;
        cyc(ACC, ACC, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
